// File: rtl/fp_accum_seq.sv
// Streaming accumulation sequencer for IEEE-754 single-precision packets.
// Drives an external combinational adder and reports the packet total, element count and sticky overflow.
module fp_accum_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic [31:0]      addA,
  output logic [31:0]      addB,
  input  logic [31:0]      addSum,
  input  logic             addOverFlow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overFlow
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ADD,
    EMIT
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [31:0]      r_acc;
  logic [31:0]      r_opB;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_lastPend;
  logic             w_accept;

  assign in_ready     = (r_state == IDLE) || (r_state == RUN);
  assign out_valid    = (r_state == EMIT);
  assign w_accept     = in_valid & in_ready;
  assign addA         = r_acc;
  assign addB         = r_opB;
  assign out_sum      = r_acc;
  assign out_count    = r_count;
  assign out_overFlow = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = in_last ? EMIT : RUN;
        end
      end
      RUN: begin
        if (w_accept) begin
          w_nextState = ADD;
        end
      end
      ADD: begin
        w_nextState = r_lastPend ? EMIT : RUN;
      end
      EMIT: begin
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The first element seeds the accumulator directly; an infinite/NaN seed already counts as overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_opB      <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_lastPend <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc   <= in_data;
            r_count <= CNT_W'(1);
            r_ovf   <= &in_data[30:23];
          end
        end
        RUN: begin
          if (w_accept) begin
            r_opB      <= in_data;
            r_lastPend <= in_last;
          end
        end
        ADD: begin
          r_acc <= addSum;
          r_ovf <= r_ovf | addOverFlow;
          if (r_count != {CNT_W{1'b1}}) begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        EMIT: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Directed self-checking bench for fp_accum_seq; the adder is a table of hand-computed float sums.
module tb_fp_accum_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [31:0] addA;
  logic [31:0] addB;
  logic [31:0] addSum;
  logic        addOverFlow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [15:0] out_count;
  logic        out_overFlow;

  int testsRun = 0;
  int testsFailed = 0;
  int cycleCnt = 0;

  fp_accum_seq #(.CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .addA         (addA),
    .addB         (addB),
    .addSum       (addSum),
    .addOverFlow  (addOverFlow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_count    (out_count),
    .out_overFlow (out_overFlow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Exact sums for the operand pairs this bench produces; anything else yields an obvious junk value.
  function automatic logic [32:0] adderModel(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] key;
    key = {a, b};
    case (key)
      64'h3F800000_40000000: return {1'b0, 32'h40400000};
      64'h40400000_40400000: return {1'b0, 32'h40C00000};
      64'h40A00000_C0000000: return {1'b0, 32'h40400000};
      64'h7F000000_7F000000: return {1'b1, 32'h7F800000};
      64'h7F800000_3F800000: return {1'b0, 32'h7F800000};
      64'h3F800000_3F800000: return {1'b0, 32'h40000000};
      default:               return {1'b0, 32'hFFFFFFFF};
    endcase
  endfunction

  always_comb {addOverFlow, addSum} = adderModel(addA, addB);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic [31:0] d, input logic last);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) checkOutput("acceptTimeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitOutValid(output int seenAt);
    int guard;
    guard = 0;
    while (!out_valid && guard < 100) begin
      tick();
      guard++;
    end
    if (!out_valid) checkOutput("outValidTimeout", 32'd0, 32'd1);
    seenAt = cycleCnt;
  endtask

  task automatic collectResult(input string tag, input logic [31:0] expSum,
                               input logic [15:0] expCount, input logic expOvf);
    int seenAt;
    waitOutValid(seenAt);
    checkOutput({tag, "_sum"}, out_sum, expSum);
    checkOutput({tag, "_count"}, {16'd0, out_count}, {16'd0, expCount});
    checkOutput({tag, "_ovf"}, {31'd0, out_overFlow}, {31'd0, expOvf});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, "_readyAfter"}, {31'd0, in_ready}, 32'd1);
    checkOutput({tag, "_validAfter"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int t0;
    int seenAt;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_inReady", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_outValid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_sum", out_sum, 32'd0);
    checkOutput("rst_count", {16'd0, out_count}, 32'd0);
    checkOutput("rst_addB", addB, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1.0 + 2.0 + 3.0 back to back: EMIT four edges after the first accept
    applyStimulus(32'h3F800000, 1'b0);
    t0 = cycleCnt;
    applyStimulus(32'h40000000, 1'b0);
    applyStimulus(32'h40400000, 1'b1);
    waitOutValid(seenAt);
    checkOutput("sum3_latency", seenAt - t0, 32'd4);
    collectResult("sum3", 32'h40C00000, 16'd3, 1'b0);

    // Single element bypasses the adder
    in_valid = 1'b1;
    in_last  = 1'b0;
    in_data  = 32'h12345678;
    in_valid = 1'b0;
    in_last  = 1'b1;
    tick();
    checkOutput("lastNoValid_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(32'hC0400000, 1'b1);
    t0 = cycleCnt;
    waitOutValid(seenAt);
    checkOutput("single_latency", seenAt - t0, 32'd0);
    collectResult("single", 32'hC0400000, 16'd1, 1'b0);

    // Mixed sign with a stall in RUN
    applyStimulus(32'h40A00000, 1'b0);
    tick();
    tick();
    applyStimulus(32'hC0000000, 1'b1);
    collectResult("mixed", 32'h40400000, 16'd2, 1'b0);

    // Overflow stays sticky through the remaining element
    applyStimulus(32'h7F000000, 1'b0);
    applyStimulus(32'h7F000000, 1'b0);
    applyStimulus(32'h3F800000, 1'b1);
    collectResult("ovf", 32'h7F800000, 16'd3, 1'b1);

    // Infinite first element flags overflow immediately
    applyStimulus(32'h7F800000, 1'b1);
    collectResult("infSeed", 32'h7F800000, 16'd1, 1'b1);

    // Output backpressure while the next packet is waiting
    applyStimulus(32'h3F800000, 1'b0);
    applyStimulus(32'h3F800000, 1'b1);
    waitOutValid(seenAt);
    in_valid = 1'b1;
    in_data  = 32'h40000000;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_inReady", {31'd0, in_ready}, 32'd0);
      checkOutput("bp_sum", out_sum, 32'h40000000);
      checkOutput("bp_count", {16'd0, out_count}, 32'd2);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("bp_release_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("bp_release_valid", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("bp_next_valid", {31'd0, out_valid}, 32'd1);
    collectResult("bpNext", 32'h40000000, 16'd1, 1'b0);

    // Reset in ADD after two of four elements discards the packet
    applyStimulus(32'h3F800000, 1'b0);
    applyStimulus(32'h40000000, 1'b0);
    checkOutput("midAdd_inReady", {31'd0, in_ready}, 32'd0);
    checkOutput("midAdd_addA", addA, 32'h3F800000);
    checkOutput("midAdd_addB", addB, 32'h40000000);
    rst_n = 1'b0;
    #1;
    checkOutput("midRst_inReady", {31'd0, in_ready}, 32'd1);
    checkOutput("midRst_outValid", {31'd0, out_valid}, 32'd0);
    checkOutput("midRst_sum", out_sum, 32'd0);
    checkOutput("midRst_count", {16'd0, out_count}, 32'd0);
    checkOutput("midRst_addA", addA, 32'd0);
    checkOutput("midRst_addB", addB, 32'd0);
    checkOutput("midRst_ovf", {31'd0, out_overFlow}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(32'h3FC00000, 1'b1);
    collectResult("fresh", 32'h3FC00000, 16'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fp_accum_seq.md
# fp_accum_seq

Streaming accumulation sequencer for IEEE-754 single-precision words. It accepts a packet of operands over a valid/ready input and drives a combinational single-precision adder: the running sum goes to operand A, the newest element to operand B, and the adder's sum and overflow flag come back. When the packet ends, the block presents the total, the element count and a sticky overflow flag on a valid/ready output. It sits directly upstream of the adder and directly consumes its result.

## Interface
- CNT_W, 16, width of the element counter; the counter saturates at all-ones.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  block can accept an element.
- in_data  in  32  IEEE-754 single-precision element.
- in_last  in  1  element is the last of its packet.
- addA  out  32  adder operand A (running sum register).
- addB  out  32  adder operand B (registered element).
- addSum  in  32  adder result, combinational from addA/addB.
- addOverFlow  in  1  adder overflow flag, combinational.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_sum  out  32  packet total.
- out_count  out  CNT_W  number of elements in the packet (saturating).
- out_overFlow  out  1  sticky overflow for the packet.

## Operation
- Registers: acc[31:0], opB[31:0], count[CNT_W-1:0], ovf, lastPend, state.
- addA = acc and addB = opB, both driven straight from registers. out_sum = acc, out_count = count, out_overFlow = ovf.
- States are IDLE, RUN, ADD and EMIT.
- in_ready = 1 in IDLE and RUN, 0 in ADD and EMIT. out_valid = 1 only in EMIT.
- IDLE, on accept (in_valid & in_ready):
  - acc <= in_data, count <= 1, ovf <= (in_data[30:23] == 8'hFF).
  - Next state is EMIT if in_last, otherwise RUN.
  - The first element is loaded directly; it is never added to zero.
- RUN, on accept: opB <= in_data, lastPend <= in_last, go to ADD. With no accept, stay in RUN.
- ADD (exactly one cycle):
  - acc <= addSum, ovf <= ovf | addOverFlow.
  - count <= count + 1, saturating at 2^CNT_W - 1.
  - Next state is EMIT if lastPend, otherwise RUN.
- EMIT: hold every output stable until out_ready = 1, then go to IDLE. acc, count and ovf keep their values until the next IDLE accept overwrites them.
- Overflow does not abort a packet; the remaining elements are still summed and ovf stays set.
- Reset (async, at any time):
  - state = IDLE; acc, opB, count, ovf and lastPend = 0.
  - Outputs: in_ready = 1, out_valid = 0, out_sum = 0, out_count = 0, out_overFlow = 0, addA = 0, addB = 0.
  - A partial packet in progress is discarded with no output.
- in_last seen with in_valid low is ignored. Only accepted beats matter.

## Timing
- Throughput: the first element of a packet takes 1 cycle; each later element takes 2 cycles (RUN accept, then ADD).
- Latency, back-to-back input: first element accepted at edge t, N elements total → out_valid is high from cycle t+2N-1.
  - N=1: out_valid from cycle t+1.
  - N=3: out_valid from cycle t+5.
- An idle in_valid in RUN only stretches the packet. No state changes except the wait.
- The adder path is combinational from registered addA/addB to acc inside one cycle. No path from in_data reaches the adder in the same cycle.
- Output handshake in EMIT:
  - The handshake at edge e moves the block to IDLE at e, so in_ready = 1 and out_valid = 0 in cycle e+1.
  - The next packet's first element can be accepted at edge e+1.
- Simultaneous in_valid and out_valid in EMIT: the input is stalled (in_ready = 0) and the output completes first.

## Test plan
- Stream 0x3F800000, 0x40000000, 0x40400000 (1.0, 2.0, 3.0), last on 3.0, out_ready=1 → out_valid at t+5 with out_sum=0x40C00000 (6.0), out_count=3, out_overFlow=0, then in_ready=1 the next cycle.
- Single element 0xC0400000 (-3.0) with in_last → out_valid at t+1, out_sum=0xC0400000, out_count=1, no adder use.
- Mixed sign 0x40A00000 (5.0) then 0xC0000000 (-2.0), last → out_sum=0x40400000 (3.0), out_count=2.
- Overflow: 0x7F000000, 0x7F000000, 0x3F800000 (last) → out_overFlow=1 (sticky through the third element), out_count=3.
- Backpressure: hold out_ready=0 for 5 cycles in EMIT while in_valid=1 → out_valid, out_sum and out_count stable, in_ready=0. Release → next packet's first element accepted one cycle later.
- Reset mid-packet: assert rst_n=0 in ADD after 2 of 4 elements → all outputs 0 immediately, in_ready=1. A fresh packet {0x3FC00000} with last yields out_sum=0x3FC00000, out_count=1.
